// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
//   Registered CH-channel, W-bit multiplexer with two modes:
//     manual : a loaded channel select is held
//     scan   : channels are visited round-robin, each held for DWELL cycles
//   The output is tagged with the channel it came from so a downstream
//   display/serial stage can consume it directly.
//
// Optional feature (macro SCAN_MUX_MASK_EN):
//   Adds ch_en[CH-1:0]. Scan skips disabled channels, manual loads of a
//   disabled channel are rejected, and an all-zero mask drops dout_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        packed channel inputs, channel k = din[k*W +: W]
//   mode       0 = manual, 1 = scan
//   sel        manual channel select
//   sel_load   load sel into the channel register (manual only)
//   ch_en      channel enable mask (SCAN_MUX_MASK_EN only)
//   dout       registered selected data
//   dout_ch    channel index dout was taken from
//   dout_valid dout/dout_ch are meaningful
//   wrap       one-cycle pulse when scan goes from the last channel to 0
//   sel_err    one-cycle pulse on an illegal manual load
// ---------------------------------------------------------------------------
module scan_mux #(
  parameter int CH    = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*W-1:0]     din,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic                sel_load,
`ifdef SCAN_MUX_MASK_EN
  input  logic [CH-1:0]       ch_en,
`endif
  output logic [W-1:0]        dout,
  output logic [SELW-1:0]     dout_ch,
  output logic                dout_valid,
  output logic                wrap,
  output logic                sel_err
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t            state_r;
  logic [SELW-1:0]   ch_r;
  logic [CNTW-1:0]   cnt_r;

  logic [CH-1:0]     en_s;
  logic [SELW:0]     nxt_s;
  logic [SELW-1:0]   ch_n_s;
  logic [CNTW-1:0]   cnt_n_s;
  logic              wrap_n_s;
  logic              err_n_s;

`ifdef SCAN_MUX_MASK_EN
  assign en_s = ch_en;
`else
  assign en_s = {CH{1'b1}};
`endif

  // Next enabled channel strictly after cur in circular order.
  // Returns {wrap, index}; wrap is set when the search crosses CH-1 -> 0,
  // except when the only enabled channel is cur itself (no movement).
  function automatic logic [SELW:0] next_enabled(input logic [SELW-1:0] cur,
                                                 input logic [CH-1:0]   en);
    logic            found;
    logic [SELW-1:0] idx;
    logic [SELW-1:0] cand;
    logic            wr;
    found = 1'b0;
    idx   = cur;
    wr    = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      cand = SELW'((32'(cur) + i) % CH);
      if (!found && en[cand]) begin
        found = 1'b1;
        idx   = cand;
        wr    = ((32'(cur) + i) >= CH) && (i != CH);
      end else begin
        found = found;
      end
    end
    return {wr, idx};
  endfunction

  assign nxt_s = next_enabled(ch_r, en_s);

  // Channel, dwell counter and pulse next-state. The mode input decides the
  // rule for this cycle; state_r only blocks a load on the scan->manual cycle.
  always_comb begin
    ch_n_s   = ch_r;
    cnt_n_s  = cnt_r;
    wrap_n_s = 1'b0;
    err_n_s  = 1'b0;
    if (mode) begin
      if (en_s == {CH{1'b0}}) begin
        cnt_n_s = {CNTW{1'b0}};
      end else if (cnt_r == CNTW'(DWELL - 1)) begin
        cnt_n_s  = {CNTW{1'b0}};
        ch_n_s   = nxt_s[SELW-1:0];
        wrap_n_s = nxt_s[SELW];
      end else begin
        cnt_n_s = cnt_r + CNTW'(1);
      end
    end else begin
      cnt_n_s = {CNTW{1'b0}};
      if (sel_load && (state_r == MANUAL)) begin
        if ((32'(sel) < CH) && en_s[sel]) begin
          ch_n_s = sel;
        end else begin
          err_n_s = 1'b1;
        end
      end else begin
        err_n_s = 1'b0;
      end
    end
  end

  // State, channel/counter registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= MANUAL;
      ch_r       <= {SELW{1'b0}};
      cnt_r      <= {CNTW{1'b0}};
      dout       <= {W{1'b0}};
      dout_ch    <= {SELW{1'b0}};
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state_r    <= mode ? SCAN : MANUAL;
      ch_r       <= ch_n_s;
      cnt_r      <= cnt_n_s;
      // Data and tag both come from the pre-update ch_r so they always agree.
      dout       <= din[ch_r*W +: W];
      dout_ch    <= ch_r;
      dout_valid <= (en_s != {CH{1'b0}});
      wrap       <= wrap_n_s;
      sel_err    <= err_n_s;
    end
  end

endmodule
